mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous data/instruction memory between three requesters: the VGA/board scan reader, the CPU datapath (fetch/load/store sequenced by the CPU control FSM), and the board fill/clear DMA engine.
- Owns the memory address, write-data and write-enable pins.
- Hands out one access per cycle with a registered grant decision, and returns read data with a per-requester valid strobe.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the VGA scan reader, CPU datapath and board DMA engine.
// One registered grant per cycle; read data returns one cycle after issue with a per-requester strobe.
module mem_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int VGA_MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        owner
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_VGA  = 2'd1;
  localparam logic [1:0] ST_CPU  = 2'd2;
  localparam logic [1:0] ST_DMA  = 2'd3;
  localparam logic [7:0] BURST_MAX = VGA_MAX_BURST[7:0];

  logic [1:0]        state_q, state_d;
  logic              rr_q, rr_d;          // 1 = DMA was last served
  logic [7:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [1:0]        rtag_q, rtag_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rr_win_s;
  logic              forced_s;

  // Next-state arbitration: forced CPU/DMA slot, then VGA, then round robin.
  always_comb begin
    if (cpu_req && dma_req) begin
      rr_win_s = rr_q ? ST_CPU : ST_DMA;
    end else if (cpu_req) begin
      rr_win_s = ST_CPU;
    end else begin
      rr_win_s = ST_DMA;
    end
    forced_s = (burst_q == BURST_MAX) && (cpu_req || dma_req);
    if (forced_s) begin
      state_d = rr_win_s;
    end else if (vga_req) begin
      state_d = ST_VGA;
    end else if (cpu_req || dma_req) begin
      state_d = rr_win_s;
    end else begin
      state_d = ST_IDLE;
    end
    case (state_d)
      ST_VGA:  burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 8'd1;
      default: burst_d = 8'd0;
    endcase
    case (state_d)
      ST_CPU:  rr_d = 1'b0;
      ST_DMA:  rr_d = 1'b1;
      default: rr_d = rr_q;
    endcase
  end

  // Issue-cycle memory drive; mem_addr keeps its last value while idle.
  always_comb begin
    vga_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    mem_addr = addr_hold_q;
    mem_din  = '0;
    mem_we   = 1'b0;
    case (state_q)
      ST_VGA: begin
        vga_gnt  = 1'b1;
        mem_addr = vga_addr;
      end
      ST_CPU: begin
        cpu_gnt  = 1'b1;
        mem_addr = cpu_addr;
        mem_din  = cpu_wdata;
        mem_we   = cpu_we;
      end
      ST_DMA: begin
        dma_gnt  = 1'b1;
        mem_addr = dma_addr;
        mem_din  = dma_wdata;
        mem_we   = dma_we;
      end
      default: begin
        mem_addr = addr_hold_q;
      end
    endcase
    addr_hold_d = mem_addr;
    if ((state_q != ST_IDLE) && !mem_we) begin
      rtag_d = state_q;
    end else begin
      rtag_d = ST_IDLE;
    end
  end

  // Read return: the tag of last cycle's read selects which strobe fires.
  always_comb begin
    vga_rvalid = (rtag_q == ST_VGA);
    cpu_rvalid = (rtag_q == ST_CPU);
    dma_rvalid = (rtag_q == ST_DMA);
    if (rtag_q != ST_IDLE) begin
      rdata = mem_dout;
    end else begin
      rdata = rdata_q;
    end
    rdata_d = rdata;
    owner   = state_q;
  end

  // State, round-robin, burst and return-path registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b1;
      burst_q     <= 8'd0;
      addr_hold_q <= '0;
      rtag_q      <= ST_IDLE;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      burst_q     <= burst_d;
      addr_hold_q <= addr_hold_d;
      rtag_q      <= rtag_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous single-port memory model.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_gnt, vga_rvalid;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [15:0] rdata, mem_addr, mem_din, mem_dout;
  logic        mem_we;
  logic [1:0]  owner;

  logic [15:0] mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .VGA_MAX_BURST(8)) dut (
    .clock(clock), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .owner(owner)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: read-before-write, one-cycle read latency, bench preload port.
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; pre_we = 1'b0; pre_addr = 16'h0; pre_data = 16'h0;
    vga_req = 1'b0; vga_addr = 16'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
    preload(16'h0040, 16'hBEEF);
    for (int k = 0; k < 4; k++) preload(16'h0100 + 16'(k), 16'hFFFF);
    preload(16'h0200, 16'h1234);
    preload(16'h0300, 16'h5678);
    preload(16'h0260, 16'h1111);
    @(negedge clock);
    check_eq("rst_owner", 32'(owner), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_mem_we", 32'(mem_we), 32'h0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    check_eq("rst_gnts", 32'({vga_gnt, cpu_gnt, dma_gnt}), 32'h0);

    // CPU single read
    reset = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0040;
    @(negedge clock);
    check_eq("t1_cpu_gnt", 32'(cpu_gnt), 32'h1);
    check_eq("t1_mem_addr", 32'(mem_addr), 32'h0040);
    check_eq("t1_mem_we", 32'(mem_we), 32'h0);
    check_eq("t1_owner", 32'(owner), 32'h2);
    cpu_req = 1'b0;
    @(negedge clock);
    check_eq("t1_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    check_eq("t1_rdata", 32'(rdata), 32'hBEEF);
    check_eq("t1_idle_owner", 32'(owner), 32'h0);
    check_eq("t1_idle_addr_hold", 32'(mem_addr), 32'h0040);

    // VGA burst limit against a continuous CPU request
    vga_req = 1'b1; vga_addr = 16'h0300; cpu_req = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      check_eq($sformatf("t2_owner_%0d", i), 32'(owner), (i == 8 || i == 17) ? 32'h2 : 32'h1);
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    @(negedge clock);

    // CPU/DMA round robin after reset, DMA writes
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_we = 1'b1; dma_wdata = 16'h0000; dma_addr = 16'h0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_eq($sformatf("t3_owner_%0d", i), 32'(owner), (i % 2 == 0) ? 32'h2 : 32'h3);
      check_eq($sformatf("t3_mem_we_%0d", i), 32'(mem_we), 32'(i % 2));
      check_eq($sformatf("t3_dma_rvalid_%0d", i), 32'(dma_rvalid), 32'h0);
      check_eq($sformatf("t3_cpu_rvalid_%0d", i), 32'(cpu_rvalid), 32'(i % 2));
      if (i % 2 == 1) check_eq($sformatf("t3_mem_addr_%0d", i), 32'(mem_addr), 32'h0100 + 32'(i / 2));
      if (i == 7) begin
        cpu_req = 1'b0; dma_req = 1'b0;
      end
      @(posedge clock); #1;
      if (i % 2 == 1) dma_addr = dma_addr + 16'h1;
    end
    @(negedge clock);
    check_eq("t3_idle_owner", 32'(owner), 32'h0);
    check_eq("t3_no_dma_rvalid", 32'(dma_rvalid), 32'h0);
    for (int k = 0; k < 4; k++) check_eq($sformatf("t3_mem_%0d", k), 32'(mem[16'h0100 + 16'(k)]), 32'h0);
    dma_we = 1'b0;

    // CPU read then VGA read, staggered returns
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    @(negedge clock);
    check_eq("t4_cpu_gnt", 32'(cpu_gnt), 32'h1);
    cpu_req = 1'b0; vga_req = 1'b1; vga_addr = 16'h0300;
    @(negedge clock);
    check_eq("t4_vga_gnt", 32'(vga_gnt), 32'h1);
    check_eq("t4_rvalids_n1", 32'({cpu_rvalid, vga_rvalid}), 32'h2);
    check_eq("t4_rdata_cpu", 32'(rdata), 32'h1234);
    vga_req = 1'b0;
    @(negedge clock);
    check_eq("t4_rvalids_n2", 32'({cpu_rvalid, vga_rvalid}), 32'h1);
    check_eq("t4_rdata_vga", 32'(rdata), 32'h5678);

    // Asynchronous reset during a CPU write with a VGA read in flight
    vga_req = 1'b1;
    @(negedge clock);
    check_eq("t5_vga_owner", 32'(owner), 32'h1);
    vga_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0250; cpu_wdata = 16'hAAAA;
    @(negedge clock);
    check_eq("t5_pre_cpu_gnt", 32'(cpu_gnt), 32'h1);
    check_eq("t5_pre_mem_we", 32'(mem_we), 32'h1);
    check_eq("t5_pre_vga_rvalid", 32'(vga_rvalid), 32'h1);
    #1 reset = 1'b0;
    #1;
    check_eq("t5_rst_mem_we", 32'(mem_we), 32'h0);
    check_eq("t5_rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
    check_eq("t5_rst_vga_rvalid", 32'(vga_rvalid), 32'h0);
    check_eq("t5_rst_owner", 32'(owner), 32'h0);
    check_eq("t5_rst_mem_addr", 32'(mem_addr), 32'h0);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0100;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("t5_first_owner", 32'(owner), 32'h2);
    check_eq("t5_first_cpu_gnt", 32'(cpu_gnt), 32'h1);
    cpu_req = 1'b0;
    @(negedge clock);
    check_eq("t5_second_owner", 32'(owner), 32'h3);
    dma_req = 1'b0;
    @(negedge clock);
    check_eq("t5_dma_rvalid", 32'(dma_rvalid), 32'h1);
    check_eq("t5_dma_rdata", 32'(rdata), 32'h0000);
    cpu_we = 1'b0;

    // Withdrawn CPU request while VGA streams
    vga_req = 1'b1; vga_addr = 16'h0300;
    @(negedge clock);
    check_eq("t6_vga_owner", 32'(owner), 32'h1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0260; cpu_wdata = 16'h5555;
    @(negedge clock);
    check_eq("t6_owner_pulse", 32'(owner), 32'h1);
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_eq($sformatf("t6_owner_%0d", i), 32'(owner), 32'h1);
      check_eq($sformatf("t6_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'h0);
      check_eq($sformatf("t6_mem_we_%0d", i), 32'(mem_we), 32'h0);
      check_eq($sformatf("t6_vga_rvalid_%0d", i), 32'(vga_rvalid), 32'h1);
    end
    vga_req = 1'b0;
    @(negedge clock);
    check_eq("t6_mem_untouched", 32'(mem[16'h0260]), 32'h1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
